// File: rtl/seq_squarer_pkg.sv
// Shared constants and types for the iterative shift-add squarer.
// Operand width default, FSM state encoding and step-counter sizing live here.
package seq_squarer_pkg;

    localparam int N_DEF = 23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CW = cnt_width(N_DEF);

endpackage

// File: rtl/seq_squarer_step.sv
// One shift-add multiply step: conditionally add the multiplicand into the
// high half, then shift the (2N+1)-bit {carry, hi, lo} right by one.
module seq_squarer_step
    import seq_squarer_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] hi_i,
    input  logic [N-1:0] lo_i,
    input  logic [N-1:0] mcand_i,
    output logic [N-1:0] hi_o,
    output logic [N-1:0] lo_o
);

    logic [N:0] sum;

    always_comb begin
        sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, mcand_i} : '0);
        // The carry lands in the top bit of hi; dropping it breaks near-full-scale operands.
        hi_o = sum[N:1];
        lo_o = {sum[0], lo_i[N-1:1]};
    end

endmodule

// File: rtl/seq_squarer.sv
// Iterative unsigned multiplier (p = a*b in N cycles) with valid/ready on both
// sides; one operation in flight, p held until the consumer takes it.
module seq_squarer
    import seq_squarer_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] p,
    output logic           busy
);

    // state   | meaning
    // IDLE    | waiting for an operand pair, in_ready high
    // RUN     | one shift-add step per cycle, N steps total
    // DONE    | product on p, waiting for out_ready

    localparam int              CW_L = cnt_width(N);
    localparam logic [CW_L-1:0] LAST = CW_L'(N - 1);

    state_e           state_q, state_d;
    logic [CW_L-1:0]  cnt_q, cnt_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     hi_q, hi_d;
    logic [N-1:0]     lo_q, lo_d;
    logic [2*N-1:0]   p_q, p_d;
    logic [N-1:0]     hi_step, lo_step;

    seq_squarer_step #(.N(N)) u_step (
        .hi_i    (hi_q),
        .lo_i    (lo_q),
        .mcand_i (mcand_q),
        .hi_o    (hi_step),
        .lo_o    (lo_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_d     = p_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mcand_d = a;
                    hi_d    = '0;
                    lo_d    = b;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                hi_d  = hi_step;
                lo_d  = lo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    p_d     = {hi_step, lo_step};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign p         = p_q;

endmodule
